// File: rtl/rs_age_dispatch_if.sv
// Issue, CDB snoop and dispatch bundle of the age-ordered reservation station.
// The master side is the decoder/ALU environment; the slave side is the station.
interface rs_age_dispatch_if #(
    parameter int TAG_W   = 5,
    parameter int NUM_CDB = 3,
    parameter int CNT_W   = 5
);
    logic                     issue_valid;
    logic [5:0]               issue_op;
    logic [31:0]              issue_inst;
    logic [31:0]              issue_pc;
    logic [31:0]              issue_imm;
    logic [TAG_W-1:0]         issue_tag;
    logic [31:0]              issue_vj;
    logic [31:0]              issue_vk;
    logic [TAG_W-1:0]         issue_qj;
    logic [TAG_W-1:0]         issue_qk;
    logic                     issue_qj_busy;
    logic                     issue_qk_busy;
    logic                     is_full_out;
    logic [CNT_W-1:0]         free_cnt;

    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*TAG_W-1:0] cdb_tag;
    logic [NUM_CDB*32-1:0]    cdb_value;

    logic                     disp_valid;
    logic                     disp_ready;
    logic [5:0]               disp_op;
    logic [31:0]              disp_inst;
    logic [31:0]              disp_vj;
    logic [31:0]              disp_vk;
    logic [31:0]              disp_imm;
    logic [31:0]              disp_pc;
    logic [TAG_W-1:0]         disp_tag;

    modport master (
        output issue_valid, issue_op, issue_inst, issue_pc, issue_imm, issue_tag,
               issue_vj, issue_vk, issue_qj, issue_qk, issue_qj_busy, issue_qk_busy,
               cdb_valid, cdb_tag, cdb_value, disp_ready,
        input  is_full_out, free_cnt, disp_valid, disp_op, disp_inst, disp_vj,
               disp_vk, disp_imm, disp_pc, disp_tag
    );

    modport slave (
        input  issue_valid, issue_op, issue_inst, issue_pc, issue_imm, issue_tag,
               issue_vj, issue_vk, issue_qj, issue_qk, issue_qj_busy, issue_qk_busy,
               cdb_valid, cdb_tag, cdb_value, disp_ready,
        output is_full_out, free_cnt, disp_valid, disp_op, disp_inst, disp_vj,
               disp_vk, disp_imm, disp_pc, disp_tag
    );
endinterface

// File: rtl/rs_age_dispatch.sv
// Reservation station with CDB snooping and oldest-ready-first dispatch
// through a valid/ready output register feeding the ALU.
module rs_age_dispatch #(
    parameter int DEPTH   = 16,
    parameter int TAG_W   = 5,
    parameter int NUM_CDB = 3,
    parameter int CNT_W   = 5
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             roll_back,
    rs_age_dispatch_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] valid_q;
    // older_q[i][j] set: entry j was issued before entry i
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [CNT_W-1:0] free_cnt_q;

    logic [5:0]       op_q     [DEPTH];
    logic [31:0]      inst_q   [DEPTH];
    logic [31:0]      pc_q     [DEPTH];
    logic [31:0]      imm_q    [DEPTH];
    logic [31:0]      vj_q     [DEPTH];
    logic [31:0]      vk_q     [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [TAG_W-1:0] qj_q     [DEPTH];
    logic [TAG_W-1:0] qk_q     [DEPTH];
    logic [DEPTH-1:0] qj_busy_q;
    logic [DEPTH-1:0] qk_busy_q;

    logic             disp_valid_q;
    logic [5:0]       disp_op_q;
    logic [31:0]      disp_inst_q;
    logic [31:0]      disp_vj_q;
    logic [31:0]      disp_vk_q;
    logic [31:0]      disp_imm_q;
    logic [31:0]      disp_pc_q;
    logic [TAG_W-1:0] disp_tag_q;

    logic [DEPTH-1:0] ready;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             full;
    logic             any_ready;
    logic             issue_acc;
    logic             disp_load;
    logic [32:0]      byp_j;
    logic [32:0]      byp_k;
    logic [32:0]      wake_j [DEPTH];
    logic [32:0]      wake_k [DEPTH];

    // {hit, value} of the lowest active broadcast channel carrying tag
    function automatic logic [32:0] cdb_lookup(
        input logic [TAG_W-1:0]         tag,
        input logic [NUM_CDB-1:0]       cvalid,
        input logic [NUM_CDB*TAG_W-1:0] ctag,
        input logic [NUM_CDB*32-1:0]    cvalue
    );
        logic [32:0] res;
        res = '0;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (cvalid[c] && (ctag[c*TAG_W +: TAG_W] == tag)) begin
                res = {1'b1, cvalue[c*32 +: 32]};
            end
        end
        return res;
    endfunction

    always_comb begin
        full     = &valid_q;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    // Oldest ready entry: ready with no older ready entry in its age row
    always_comb begin
        ready   = valid_q & ~qj_busy_q & ~qk_busy_q;
        sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i] && ((older_q[i] & ready) == '0)) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wake_j[i] = cdb_lookup(qj_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
            wake_k[i] = cdb_lookup(qk_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        end
    end

    assign any_ready = |ready;
    assign issue_acc = bus.issue_valid && !full;
    assign disp_load = any_ready && (!disp_valid_q || bus.disp_ready);
    assign byp_j     = cdb_lookup(bus.issue_qj, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
    assign byp_k     = cdb_lookup(bus.issue_qk, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);

    // ---- control and dispatch register stage ----
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q      <= '0;
            older_q      <= '{default: '0};
            free_cnt_q   <= CNT_W'(DEPTH);
            disp_valid_q <= 1'b0;
            disp_op_q    <= '0;
            disp_inst_q  <= '0;
            disp_vj_q    <= '0;
            disp_vk_q    <= '0;
            disp_imm_q   <= '0;
            disp_pc_q    <= '0;
            disp_tag_q   <= '0;
        end else if (rdy_in) begin
            if (roll_back) begin
                valid_q      <= '0;
                older_q      <= '{default: '0};
                free_cnt_q   <= CNT_W'(DEPTH);
                disp_valid_q <= 1'b0;
            end else begin
                // free_idx is empty and sel_idx is valid, so they never collide
                if (issue_acc) begin
                    valid_q[free_idx] <= 1'b1;
                    for (int i = 0; i < DEPTH; i++) begin
                        older_q[i][free_idx] <= 1'b0;
                    end
                    older_q[free_idx] <= valid_q;
                end
                if (disp_load) begin
                    valid_q[sel_idx] <= 1'b0;
                    disp_valid_q     <= 1'b1;
                    disp_op_q        <= op_q[sel_idx];
                    disp_inst_q      <= inst_q[sel_idx];
                    disp_vj_q        <= vj_q[sel_idx];
                    disp_vk_q        <= vk_q[sel_idx];
                    disp_imm_q       <= imm_q[sel_idx];
                    disp_pc_q        <= pc_q[sel_idx];
                    disp_tag_q       <= tag_q[sel_idx];
                end else if (bus.disp_ready) begin
                    disp_valid_q <= 1'b0;
                end
                free_cnt_q <= free_cnt_q + CNT_W'(disp_load) - CNT_W'(issue_acc);
            end
        end
    end

    // ---- entry payload stage: issue write with bypass, CDB wakeup ----
    always_ff @(posedge clk_in) begin
        if (rdy_in && !roll_back) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (issue_acc && (free_idx == IDX_W'(i))) begin
                    op_q[i]      <= bus.issue_op;
                    inst_q[i]    <= bus.issue_inst;
                    pc_q[i]      <= bus.issue_pc;
                    imm_q[i]     <= bus.issue_imm;
                    tag_q[i]     <= bus.issue_tag;
                    qj_q[i]      <= bus.issue_qj;
                    qk_q[i]      <= bus.issue_qk;
                    qj_busy_q[i] <= bus.issue_qj_busy && !byp_j[32];
                    qk_busy_q[i] <= bus.issue_qk_busy && !byp_k[32];
                    vj_q[i]      <= (bus.issue_qj_busy && byp_j[32]) ? byp_j[31:0] : bus.issue_vj;
                    vk_q[i]      <= (bus.issue_qk_busy && byp_k[32]) ? byp_k[31:0] : bus.issue_vk;
                end else if (valid_q[i]) begin
                    if (qj_busy_q[i] && wake_j[i][32]) begin
                        qj_busy_q[i] <= 1'b0;
                        vj_q[i]      <= wake_j[i][31:0];
                    end
                    if (qk_busy_q[i] && wake_k[i][32]) begin
                        qk_busy_q[i] <= 1'b0;
                        vk_q[i]      <= wake_k[i][31:0];
                    end
                end
            end
        end
    end

    assign bus.is_full_out = full;
    assign bus.free_cnt    = free_cnt_q;
    assign bus.disp_valid  = disp_valid_q;
    assign bus.disp_op     = disp_op_q;
    assign bus.disp_inst   = disp_inst_q;
    assign bus.disp_vj     = disp_vj_q;
    assign bus.disp_vk     = disp_vk_q;
    assign bus.disp_imm    = disp_imm_q;
    assign bus.disp_pc     = disp_pc_q;
    assign bus.disp_tag    = disp_tag_q;
endmodule

// File: tb/tb_rs_age_dispatch.sv
// Directed bench for rs_age_dispatch: dispatch scoreboard plus direct checks
// of reset, latency, stall, full and roll_back behaviour.
module tb_rs_age_dispatch;
    logic clk_in    = 1'b0;
    logic rst_in    = 1'b0;
    logic rdy_in    = 1'b1;
    logic roll_back = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [74:0] sb [$];
    logic [74:0] exp_v;

    always #5 clk_in = ~clk_in;

    rs_age_dispatch_if #(.TAG_W(5), .NUM_CDB(3), .CNT_W(5)) bus ();

    rs_age_dispatch #(.DEPTH(16), .TAG_W(5), .NUM_CDB(3), .CNT_W(5)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .roll_back (roll_back),
        .bus       (bus)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_issue(input logic [4:0] tag, input logic [31:0] vj, input logic [31:0] vk,
                               input logic [4:0] qj, input logic qjb,
                               input logic [4:0] qk, input logic qkb);
        bus.issue_valid   = 1'b1;
        bus.issue_op      = 6'(tag) + 6'd1;
        bus.issue_inst    = {27'h0, tag};
        bus.issue_pc      = 32'h1000 + 32'(tag);
        bus.issue_imm     = 32'h7700 + 32'(tag);
        bus.issue_tag     = tag;
        bus.issue_vj      = vj;
        bus.issue_vk      = vk;
        bus.issue_qj      = qj;
        bus.issue_qj_busy = qjb;
        bus.issue_qk      = qk;
        bus.issue_qk_busy = qkb;
    endtask

    task automatic push_exp(input logic [4:0] tag, input logic [31:0] vj, input logic [31:0] vk);
        sb.push_back({6'(tag) + 6'd1, tag, vj, vk});
    endtask

    task automatic set_cdb(input int ch, input logic [4:0] tag, input logic [31:0] val);
        bus.cdb_valid[ch]          = 1'b1;
        bus.cdb_tag[ch*5 +: 5]     = tag;
        bus.cdb_value[ch*32 +: 32] = val;
    endtask

    // Handshakes are taken at the next posedge; compare them against the queue
    always @(negedge clk_in) begin
        if (!rst_in && rdy_in && !roll_back && bus.disp_valid && bus.disp_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL sb_unexpected observed_tag=%0h expected=no_dispatch", bus.disp_tag);
            end
            if (sb.size() != 0) begin
                exp_v = sb.pop_front();
                chk("sb_dispatch", 128'({bus.disp_op, bus.disp_tag, bus.disp_vj, bus.disp_vk}), 128'(exp_v));
            end
        end
    end

    initial begin
        bus.issue_valid = 1'b0;
        drive_issue(5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0);
        bus.issue_valid = 1'b0;
        bus.cdb_valid   = '0;
        bus.cdb_tag     = '0;
        bus.cdb_value   = '0;
        bus.disp_ready  = 1'b1;

        // T1: asynchronous reset with no clock edge
        #1 rst_in = 1'b1;
        #1;
        chk("t1_disp_valid", 128'(bus.disp_valid), 128'(0));
        chk("t1_free_cnt", 128'(bus.free_cnt), 128'(16));
        chk("t1_full", 128'(bus.is_full_out), 128'(0));
        chk("t1_disp_tag", 128'(bus.disp_tag), 128'(0));
        chk("t1_disp_vj", 128'(bus.disp_vj), 128'(0));
        #1 rst_in = 1'b0;
        tick();

        // T1b: mid-operation reset between edges drops pending entries
        drive_issue(5'd20, 32'h0, 32'h1, 5'd30, 1'b1, 5'd0, 1'b0);
        tick();
        drive_issue(5'd21, 32'h0, 32'h2, 5'd30, 1'b1, 5'd0, 1'b0);
        tick();
        bus.issue_valid = 1'b0;
        chk("t1b_free_before", 128'(bus.free_cnt), 128'(14));
        #3 rst_in = 1'b1;
        #1;
        chk("t1b_free_after", 128'(bus.free_cnt), 128'(16));
        chk("t1b_full_after", 128'(bus.is_full_out), 128'(0));
        #1 rst_in = 1'b0;
        tick();
        set_cdb(0, 5'd30, 32'h3030);
        tick();
        bus.cdb_valid = '0;
        tick(); tick(); tick();
        chk("t1b_no_dispatch", 128'(bus.disp_valid), 128'(0));

        // T2: age order B, C, A with A woken by cdb0 in cycle 4
        drive_issue(5'd1, 32'h0, 32'h11, 5'd3, 1'b1, 5'd0, 1'b0);
        tick();
        drive_issue(5'd2, 32'h22, 32'h23, 5'd0, 1'b0, 5'd0, 1'b0);
        push_exp(5'd2, 32'h22, 32'h23);
        tick();
        drive_issue(5'd3, 32'h33, 32'h34, 5'd0, 1'b0, 5'd0, 1'b0);
        push_exp(5'd3, 32'h33, 32'h34);
        tick();
        bus.issue_valid = 1'b0;
        chk("t2_first_tag", 128'(bus.disp_tag), 128'(2));
        set_cdb(0, 5'd3, 32'h333);
        push_exp(5'd1, 32'h333, 32'h11);
        tick();
        bus.cdb_valid = '0;
        tick(); tick(); tick();
        chk("t2_drained", 128'(sb.size()), 128'(0));
        chk("t2_free_cnt", 128'(bus.free_cnt), 128'(16));

        // T3: issue bypass, channel priority at issue and at wakeup, latency
        drive_issue(5'd5, 32'h0BAD, 32'h55, 5'd7, 1'b1, 5'd0, 1'b0);
        set_cdb(1, 5'd7, 32'hDEAD);
        push_exp(5'd5, 32'hDEAD, 32'h55);
        tick();
        bus.cdb_valid = '0;
        chk("t3_lat_edge1", 128'(bus.disp_valid), 128'(0));
        drive_issue(5'd6, 32'h66, 32'h0BAD, 5'd8, 1'b0, 5'd7, 1'b1);
        set_cdb(0, 5'd7, 32'hAAAA);
        set_cdb(1, 5'd9, 32'hBBBB);
        set_cdb(2, 5'd7, 32'hCCCC);
        push_exp(5'd6, 32'h66, 32'hAAAA);
        tick();
        bus.cdb_valid = '0;
        chk("t3_lat_edge2", 128'(bus.disp_valid), 128'(1));
        chk("t3_lat_tag", 128'(bus.disp_tag), 128'(5));
        drive_issue(5'd10, 32'h0BAD, 32'h10, 5'd12, 1'b1, 5'd0, 1'b0);
        tick();
        bus.issue_valid = 1'b0;
        set_cdb(1, 5'd12, 32'h1111);
        set_cdb(2, 5'd12, 32'h2222);
        push_exp(5'd10, 32'h1111, 32'h10);
        tick();
        bus.cdb_valid = '0;
        tick(); tick(); tick();
        chk("t3_drained", 128'(sb.size()), 128'(0));

        // T4: output stall with three ready entries behind the held one
        bus.disp_ready = 1'b0;
        for (int k = 13; k <= 16; k++) begin
            drive_issue(5'(k), 32'h100 + 32'(k), 32'h200 + 32'(k), 5'd0, 1'b0, 5'd0, 1'b0);
            push_exp(5'(k), 32'h100 + 32'(k), 32'h200 + 32'(k));
            tick();
        end
        bus.issue_valid = 1'b0;
        chk("t4_free_cnt", 128'(bus.free_cnt), 128'(13));
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4_hold_valid", 128'(bus.disp_valid), 128'(1));
            chk("t4_hold_tag", 128'({bus.disp_tag, bus.disp_vj}), 128'({5'd13, 32'h10D}));
        end
        chk("t4_free_hold", 128'(bus.free_cnt), 128'(13));
        bus.disp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_release_tag", 128'(bus.disp_tag), 128'(14 + k));
        end
        tick();
        chk("t4_empty_valid", 128'(bus.disp_valid), 128'(0));
        chk("t4_drained", 128'(sb.size()), 128'(0));

        // T5: fill all 16 slots, 17th ignored, freed slot reusable next cycle
        bus.disp_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            drive_issue(5'(k), 32'h0, 32'h5, (k == 0) ? 5'd30 : 5'd31, 1'b1, 5'd0, 1'b0);
            tick();
        end
        chk("t5_full", 128'(bus.is_full_out), 128'(1));
        chk("t5_free_zero", 128'(bus.free_cnt), 128'(0));
        drive_issue(5'd20, 32'h2020, 32'h2021, 5'd0, 1'b0, 5'd0, 1'b0);
        set_cdb(0, 5'd30, 32'h3030);
        tick();
        bus.cdb_valid = '0;
        chk("t5_drop_17th", 128'(bus.free_cnt), 128'(0));
        tick();
        chk("t5_disp_free", 128'(bus.free_cnt), 128'(1));
        chk("t5_disp_notfull", 128'(bus.is_full_out), 128'(0));
        chk("t5_disp_entry", 128'({bus.disp_valid, bus.disp_tag, bus.disp_vj}), 128'({1'b1, 5'd0, 32'h3030}));
        tick();
        bus.issue_valid = 1'b0;
        chk("t5_refill_free", 128'(bus.free_cnt), 128'(0));
        chk("t5_refill_full", 128'(bus.is_full_out), 128'(1));

        // T6: roll_back held off by rdy_in=0, then flushes everything
        rdy_in    = 1'b0;
        roll_back = 1'b1;
        drive_issue(5'd22, 32'h1, 32'h2, 5'd0, 1'b0, 5'd0, 1'b0);
        set_cdb(0, 5'd31, 32'h3131);
        tick();
        chk("t6_hold_free", 128'(bus.free_cnt), 128'(0));
        chk("t6_hold_disp", 128'({bus.disp_valid, bus.disp_tag}), 128'({1'b1, 5'd0}));
        rdy_in = 1'b1;
        bus.cdb_valid = '0;
        tick();
        chk("t6_flush_free", 128'(bus.free_cnt), 128'(16));
        chk("t6_flush_disp", 128'(bus.disp_valid), 128'(0));
        chk("t6_flush_full", 128'(bus.is_full_out), 128'(0));
        roll_back       = 1'b0;
        bus.issue_valid = 1'b0;
        bus.disp_ready  = 1'b1;
        set_cdb(0, 5'd31, 32'h3131);
        tick();
        bus.cdb_valid = '0;
        tick(); tick(); tick();
        chk("t6_no_dispatch", 128'(bus.disp_valid), 128'(0));
        chk("t6_free_after", 128'(bus.free_cnt), 128'(16));

        // T7: station keeps working after the flush
        drive_issue(5'd9, 32'h99, 32'h98, 5'd0, 1'b0, 5'd0, 1'b0);
        push_exp(5'd9, 32'h99, 32'h98);
        tick();
        bus.issue_valid = 1'b0;
        tick(); tick(); tick();
        chk("t7_drained", 128'(sb.size()), 128'(0));
        chk("t7_free_cnt", 128'(bus.free_cnt), 128'(16));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
